// File: rtl/fpu_adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder in the FPU datapath.
// Holds the segment-count function, the full-adder cell and the per-stage control payload.
package fpu_adder_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int num_seg(input int data_width, input int seg_width);
    return (seg_width > 0) ? data_width / seg_width : 0;
  endfunction

  // Full-adder cell, returns {carry_out, sum_bit}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/rpa_segment.sv
// Combinational SEG_WIDTH-bit ripple chain of full-adder cells.
// Also exposes the carry into the segment MSB so the top stage can derive signed overflow.
module rpa_segment
  import fpu_adder_pkg::*;
#(
  parameter int SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0] a_in,
  input  logic [SEG_WIDTH-1:0] b_in,
  input  logic                 c_in,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 c_out,
  output logic                 c_msb_in
);

  logic [SEG_WIDTH:0] carry;

  // NOTE: every variable written here gets a full default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      {carry[i+1], sum[i]} = fa(a_in[i], b_in[i], carry[i]);
    end
  end

  assign c_out    = carry[SEG_WIDTH];
  assign c_msb_in = carry[SEG_WIDTH-1];

endmodule

// File: rtl/rpa_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG_WIDTH segment rippled per stage,
// valid/ready flow control with a global stall enable, registered sum and flags.
module rpa_pipe_adder
  import fpu_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  c_in,
  input  logic                  sub_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  c_out,
  output logic                  ovf_out,
  output logic                  zero_out
);

  localparam int NUM_SEG = num_seg(DATA_WIDTH, SEG_WIDTH);

  if ((SEG_WIDTH < 1) || (NUM_SEG < 1) || (NUM_SEG * SEG_WIDTH != DATA_WIDTH)) begin : g_bad_params
    $error("rpa_pipe_adder: DATA_WIDTH (%0d) must be a positive multiple of SEG_WIDTH (%0d)",
           DATA_WIDTH, SEG_WIDTH);
  end

  // Operands travel whole: lower segments of a/b are dead once rippled, s fills in bottom-up.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] s;
    stage_ctrl_t           ctrl;
  } stage_t;

  logic en;

  // The whole pipeline freezes while a finished result is waiting downstream.
  assign en        = ready_in || !valid_out;
  assign ready_out = en;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    stage_t                d;
    logic [SEG_WIDTH-1:0]  seg_sum;
    logic                  seg_c;
    logic                  seg_cm;
    logic [DATA_WIDTH-1:0] s_nx;

    if (k == 0) begin : g_head
      assign d = '{a: a_in, b: (sub_in ? ~b_in : b_in), s: '0,
                   ctrl: '{valid: valid_in, carry: c_in}};
    end else begin : g_body
      assign d = g_stage[k-1].g_reg.q;
    end

    rpa_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .a_in     (d.a[k*SEG_WIDTH +: SEG_WIDTH]),
      .b_in     (d.b[k*SEG_WIDTH +: SEG_WIDTH]),
      .c_in     (d.ctrl.carry),
      .sum      (seg_sum),
      .c_out    (seg_c),
      .c_msb_in (seg_cm)
    );

    always_comb begin
      s_nx                             = d.s;
      s_nx[k*SEG_WIDTH +: SEG_WIDTH]   = seg_sum;
    end

    if (k < NUM_SEG - 1) begin : g_reg
      stage_t q;

      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (en) begin
          q.ctrl.valid <= d.ctrl.valid;
          if (d.ctrl.valid) begin
            q.a          <= d.a;
            q.b          <= d.b;
            q.s          <= s_nx;
            q.ctrl.carry <= seg_c;
          end
        end
      end
    end else begin : g_out
      logic unused_bits;

      assign unused_bits = ^{d.a, d.b, d.s};

      // Flags load only with a real beat, so they never drift behind a bubble.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_out <= 1'b0;
          sum       <= '0;
          c_out     <= 1'b0;
          ovf_out   <= 1'b0;
          zero_out  <= 1'b0;
        end else if (en) begin
          valid_out <= d.ctrl.valid;
          if (d.ctrl.valid) begin
            sum      <= s_nx;
            c_out    <= seg_c;
            ovf_out  <= seg_cm ^ seg_c;
            zero_out <= (s_nx == '0);
          end
        end
      end
    end
  end

endmodule
